pixel_word_packer: RTL and testbench
====================================

// Module: pixel_word_packer
// PURPOSE
//  Downstream stage of the image-processing top: consumes its 8-bit filtered-pixel master stream.
//  Packs pixels into 32-bit AXI4-Stream words for the DMA write path.
//  Marks start-of-frame on tuser and end-of-frame on tlast.
//  Closes every row on a word boundary, so each DMA line starts aligned.
// PARAMETERS
//  IMG_WIDTH     512  pixels per row (>=1; need not be a multiple of PIX_PER_WORD)
//  IMG_HEIGHT    512  rows per frame (>=1)
//  PIX_PER_WORD  4    pixels per output word; fixed at 4 for a 32-bit tdata
// PORTS
//  axi_clk         in   1   single clock for all logic
//  axi_reset_n     in   1   reset: asynchronous assert, active-low
//  s_pix_valid     in   1   filtered pixel valid
//  s_pix_data      in   8   filtered pixel
//  s_pix_ready     out  1   pixel accepted when s_pix_valid && s_pix_ready
//  i_flush         in   1   abort frame: emit the pending partial word, then restart counters
//  m_axis_tvalid   out  1   output word valid
//  m_axis_tdata    out  32  packed pixels, first pixel in [7:0]
//  m_axis_tkeep    out  4   byte enables, contiguous from bit 0
//  m_axis_tlast    out  1   last word of frame (or of a flushed frame)
//  m_axis_tuser    out  1   first word of frame
//  m_axis_tready   in   1   downstream ready
//  o_frame_done    out  1   1-cycle pulse when the tlast word is accepted downstream
// BEHAVIOUR
//  Reset values: all outputs 0, except s_pix_ready = 1 one cycle after reset release.
//   - Counters and the pack register are cleared; the FIFO is emptied.
//   - Reset mid-frame discards the partial frame; the next pixel after reset is frame pixel 0.
//  Pack register:
//   - Accepted pixel goes to byte lane = col % 4.
//   - The word closes (is pushed to the FIFO) when lane 3 is filled or col == IMG_WIDTH-1.
//   - tkeep = (1 << lanes_filled) - 1.
//  Counters:
//   - col wraps to 0 at IMG_WIDTH-1; row increments on that wrap.
//   - row wraps to 0 at IMG_HEIGHT-1 together with col; that word gets tlast=1.
//   - tuser=1 on the word containing pixel (row 0, col 0).
//  Output FIFO:
//   - 2 entries of {tdata, tkeep, tlast, tuser}; m_axis_* is driven from the FIFO head.
//   - Push and pop in the same cycle are both performed; occupancy is unchanged.
//  s_pix_ready = !fifo_full && !i_flush (registered full flag; no tready->ready combinational path).
//  Latency: the pixel that closes a word -> m_axis_tvalid on the next cycle, provided the FIFO was empty.
//  Backpressure:
//   - When the FIFO is full, s_pix_ready is low.
//   - The pack register holds its lanes.
//   - Head data is stable while tvalid && !tready.
//  i_flush, level-sensitive, checked each cycle:
//   - If the pack register is non-empty and the FIFO is not full: push the partial word with
//     tlast=1 and its current tkeep, then clear col, row and lanes.
//   - If the pack register is empty: clear col and row only; no word is emitted.
//   - If the FIFO is full: hold the flush until space is available.
//   - A pixel offered during flush is not accepted (s_pix_ready=0).
//  o_frame_done pulses for each accepted tlast word, including flushed ones.
// STRUCTURE
//  Package img_pkg:
//   - localparams PIX_W=8, WORD_W=32, PIX_PER_WORD=4.
//   - typedef of the FIFO entry {tdata, tkeep, tlast, tuser}.
//   - helper function keep_from_count(n).
//  Sub-module axis_fifo2:
//   - 2-deep registered FIFO with valid/ready on both sides and a full flag.
//   - Reusable by other stream stages.
//  Top module: pack register, col/row counters, flush logic, frame-done pulse.
// TESTING
//  1. IMG_WIDTH=8, IMG_HEIGHT=2, pixels 0x00..0x0F, tready=1 -> 4 words:
//     - 0x03020100 (tuser=1), 0x07060504, 0x0B0A0908, 0x0F0E0D0C (tlast=1);
//     - every tkeep=0xF; one o_frame_done pulse.
//  2. IMG_WIDTH=6, IMG_HEIGHT=1, pixels 0x10..0x15 -> 2 words:
//     - 0x13121110 with tkeep=0xF;
//     - 0x00001514 with tkeep=0x3, tlast=1.
//  3. Hold tready=0 while streaming:
//     - s_pix_ready drops once 2 words are queued;
//     - head data stays stable;
//     - releasing tready resumes with no loss or duplication.
//  4. After 3 pixels (0xA0,0xA1,0xA2), assert i_flush for 1 cycle:
//     - word 0x00A2A1A0 with tkeep=0x7, tlast=1, and an o_frame_done pulse;
//     - the next pixel carries tuser=1.
//  5. Deassert axi_reset_n mid-row (async, between clock edges):
//     - m_axis_tvalid=0 immediately;
//     - after release, the first pixel packs into lane 0 with tuser=1.
//  6. Random valid/ready, 3 frames at 512x512 -> scoreboard matches a byte-exact reference model.

Source files
------------

// File: rtl/img_pkg.sv
// Shared widths, the output-stream word layout and the tkeep helper for the pixel stream stages.
package img_pkg;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 4;
  localparam int KEEP_W       = WORD_W / 8;

  typedef struct packed {
    logic [WORD_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tuser;
  } axis_word_t;

  // Contiguous byte enables for the first n lanes; n ranges over 0..PIX_PER_WORD.
  function automatic logic [KEEP_W-1:0] keep_from_count(input logic [2:0] n);
    logic [KEEP_W:0] w_ones;
    w_ones = ({{KEEP_W{1'b0}}, 1'b1} << n) - {{KEEP_W{1'b0}}, 1'b1};
    return w_ones[KEEP_W-1:0];
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry registered stream FIFO; ready and full come straight from the occupancy register.
module axis_fifo2 #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_s_valid,
  input  logic [W-1:0] i_s_data,
  output logic         o_s_ready,
  output logic         o_m_valid,
  output logic [W-1:0] o_m_data,
  input  logic         i_m_ready,
  output logic         o_full
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_s_ready = !o_full;
  assign o_m_valid = (r_count != 2'd0);
  assign o_m_data  = r_mem[r_rd_ptr];
  assign w_push    = i_s_valid && o_s_ready;
  assign w_pop     = o_m_valid && i_m_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_s_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs 8-bit pixels into 32-bit stream words, closing every row on a word boundary,
// with tuser on the first word of a frame, tlast on the last, and a level-sensitive flush.
module pixel_word_packer
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              s_pix_valid,
  input  logic [PIX_W-1:0]  s_pix_data,
  output logic              s_pix_ready,
  input  logic              i_flush,
  output logic              m_axis_tvalid,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic              m_axis_tready,
  output logic              o_frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [2:0]        r_lanes;
  logic [WORD_W-1:0] r_data;
  logic              r_sof;
  logic              r_ready_en;

  logic              w_full;
  logic              w_fifo_in_ready;
  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_close;
  logic              w_flush_push;
  logic              w_push;
  logic              w_sof_now;
  logic [WORD_W-1:0] w_data;
  axis_word_t        w_word;
  axis_word_t        w_head;

  assign s_pix_ready  = r_ready_en && !w_full && !i_flush;
  assign w_accept     = s_pix_valid && s_pix_ready;
  assign w_last_col   = (r_col == CW'(IMG_WIDTH - 1));
  assign w_last_row   = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_close      = w_accept && ((r_lanes == 3'd3) || w_last_col);
  assign w_flush_push = i_flush && (r_lanes != 3'd0) && !w_full;
  assign w_push       = (w_close || w_flush_push) && w_fifo_in_ready;
  assign w_sof_now    = r_sof || ((r_row == '0) && (r_col == '0));

  // Rows always close on a word boundary, so the lane count doubles as col % 4.
  always_comb begin
    w_data = r_data;
    w_data[{r_lanes[1:0], 3'b000} +: PIX_W] = s_pix_data;
    w_word = '0;
    if (i_flush) begin
      w_word.tdata = r_data;
      w_word.tkeep = keep_from_count(r_lanes);
      w_word.tlast = 1'b1;
      w_word.tuser = r_sof;
    end else begin
      w_word.tdata = w_data;
      w_word.tkeep = keep_from_count(r_lanes + 3'd1);
      w_word.tlast = w_last_col && w_last_row;
      w_word.tuser = w_sof_now;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_lanes    <= 3'd0;
      r_data     <= '0;
      r_sof      <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (i_flush) begin
        // A non-empty pack register waits for FIFO space; an empty one just restarts the frame.
        if ((r_lanes == 3'd0) || !w_full) begin
          r_col   <= '0;
          r_row   <= '0;
          r_lanes <= 3'd0;
          r_data  <= '0;
          r_sof   <= 1'b0;
        end
      end else if (w_accept) begin
        if (w_close) begin
          r_lanes <= 3'd0;
          r_data  <= '0;
          r_sof   <= 1'b0;
        end else begin
          r_lanes <= r_lanes + 3'd1;
          r_data  <= w_data;
          r_sof   <= w_sof_now;
        end
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  axis_fifo2 #(.W($bits(axis_word_t))) u_fifo (
    .i_clk     (axi_clk),
    .i_rst_n   (axi_reset_n),
    .i_s_valid (w_push),
    .i_s_data  (w_word),
    .o_s_ready (w_fifo_in_ready),
    .o_m_valid (m_axis_tvalid),
    .o_m_data  (w_head),
    .i_m_ready (m_axis_tready),
    .o_full    (w_full)
  );

  assign m_axis_tdata = w_head.tdata;
  assign m_axis_tkeep = w_head.tkeep;
  assign m_axis_tlast = w_head.tlast;
  assign m_axis_tuser = w_head.tuser;
  assign o_frame_done = m_axis_tvalid && m_axis_tready && w_head.tlast;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed and randomized checks of pixel_word_packer on a small 10x3 frame against a
// pixel-position reference model; words are compared as {tdata, tkeep, tlast, tuser}.
module tb_pixel_word_packer;

  localparam int W = 10;
  localparam int H = 3;

  typedef logic [37:0] word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_pix_valid;
  logic [7:0]  s_pix_data;
  logic        s_pix_ready;
  logic        i_flush;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic        o_frame_done;

  always #5 clk = ~clk;

  pixel_word_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .axi_clk       (clk),
    .axi_reset_n   (rst_n),
    .s_pix_valid   (s_pix_valid),
    .s_pix_data    (s_pix_data),
    .s_pix_ready   (s_pix_ready),
    .i_flush       (i_flush),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .o_frame_done  (o_frame_done)
  );

  // Scoreboard and reference model state
  word_t      exp_q[$];
  word_t      got_q[$];
  logic [7:0] pend_q[$];
  int         pos;
  bit         pend_user;
  bit         armed;
  bit         last_acc;
  bit         rand_rdy;
  int         fd_count;
  int         n_cmp;
  int         n_err;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input logic [7:0] b[$], input bit last, input bit user);
    logic [31:0] d;
    logic [3:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < b.size(); i++) begin
      d[8*i +: 8] = b[i];
      k[i]        = 1'b1;
    end
    return {d, k, last, user};
  endfunction

  // Frame position drives everything: col = pos % W, frame ends at pos W*H-1.
  task automatic model_accept(input logic [7:0] pix);
    int  col;
    bit  last;
    col  = pos % W;
    last = (pos == W * H - 1);
    if (pos == 0) pend_user = 1'b1;
    pend_q.push_back(pix);
    if (pend_q.size() == 4 || col == W - 1) begin
      exp_q.push_back(mk(pend_q, last, pend_user));
      pend_q.delete();
      pend_user = 1'b0;
    end
    pos = last ? 0 : pos + 1;
  endtask

  task automatic model_step();
    bit    full;
    bit    exp_rdy;
    bit    fd_exp;
    word_t obs;
    full    = (exp_q.size() == 2);
    exp_rdy = armed && !full && !i_flush;
    obs     = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    fd_exp  = 1'b0;
    if (exp_q.size() != 0) fd_exp = m_axis_tready && exp_q[0][1];
    chk("s_pix_ready", 38'(s_pix_ready), 38'(exp_rdy));
    chk("tvalid", 38'(m_axis_tvalid), 38'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("head_word", obs, exp_q[0]);
    chk("frame_done", 38'(o_frame_done), 38'(fd_exp));
    if (o_frame_done) fd_count++;
    last_acc = 1'b0;
    if (exp_q.size() != 0 && m_axis_tready) begin
      got_q.push_back(obs);
      void'(exp_q.pop_front());
    end
    if (i_flush) begin
      if (pend_q.size() == 0) begin
        pos = 0;
      end else if (!full) begin
        exp_q.push_back(mk(pend_q, 1'b1, pend_user));
        pend_q.delete();
        pend_user = 1'b0;
        pos       = 0;
      end
    end else if (s_pix_valid && exp_rdy) begin
      model_accept(s_pix_data);
      last_acc = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    if (rst_n) armed = 1'b1;
    #1;
    if (rand_rdy) m_axis_tready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic push_pix(input logic [7:0] p);
    bit done;
    done        = 1'b0;
    s_pix_valid = 1'b1;
    s_pix_data  = p;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      done = last_acc;
    end
    chk("pixel_accept_timeout", 38'(done), 38'(1));
    s_pix_valid = 1'b0;
  endtask

  task automatic flush_cycle();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  task automatic drain();
    rand_rdy      = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_timeout", 38'(exp_q.size()), 38'(0));
  endtask

  function automatic word_t got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 'x;
  endfunction

  word_t t1_exp [9];
  word_t head_snap;

  initial begin
    t1_exp[0] = {32'h03020100, 4'hF, 1'b0, 1'b1};
    t1_exp[1] = {32'h07060504, 4'hF, 1'b0, 1'b0};
    t1_exp[2] = {32'h00000908, 4'h3, 1'b0, 1'b0};
    t1_exp[3] = {32'h0D0C0B0A, 4'hF, 1'b0, 1'b0};
    t1_exp[4] = {32'h11100F0E, 4'hF, 1'b0, 1'b0};
    t1_exp[5] = {32'h00001312, 4'h3, 1'b0, 1'b0};
    t1_exp[6] = {32'h17161514, 4'hF, 1'b0, 1'b0};
    t1_exp[7] = {32'h1B1A1918, 4'hF, 1'b0, 1'b0};
    t1_exp[8] = {32'h00001D1C, 4'h3, 1'b1, 1'b0};

    n_cmp = 0; n_err = 0; fd_count = 0; pos = 0; pend_user = 0;
    armed = 0; last_acc = 0; rand_rdy = 0;
    rst_n = 1'b0; s_pix_valid = 1'b0; s_pix_data = '0; i_flush = 1'b0; m_axis_tready = 1'b0;

    // Reset state
    #2;
    chk("rst_tvalid", 38'(m_axis_tvalid), 38'(0));
    chk("rst_word", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 38'(0));
    chk("rst_ready", 38'(s_pix_ready), 38'(0));
    chk("rst_frame_done", 38'(o_frame_done), 38'(0));
    #10 rst_n = 1'b1;
    @(posedge clk);
    armed = 1'b1;
    #1;
    chk("ready_after_release", 38'(s_pix_ready), 38'(1));

    // Full frame of incrementing pixels with tready held high
    m_axis_tready = 1'b1;
    for (int p = 0; p < W * H; p++) push_pix(8'(p));
    drain();
    chk("t1_word_count", 38'(got_q.size()), 38'(9));
    for (int i = 0; i < 9; i++) chk("t1_word", got_at(i), t1_exp[i]);
    chk("t1_frame_done_count", 38'(fd_count), 38'(1));

    // Backpressure: two queued words stop the pixel side
    got_q.delete();
    m_axis_tready = 1'b0;
    s_pix_valid   = 1'b1;
    s_pix_data    = 8'h40;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_acc) s_pix_data = s_pix_data + 8'h01;
    end
    chk("bp_ready_low", 38'(s_pix_ready), 38'(0));
    chk("bp_pixels_taken", 38'(s_pix_data), 38'(8'h48));
    head_snap = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    chk("bp_head_value", head_snap, {32'h43424140, 4'hF, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_head_stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, head_snap);
    end
    s_pix_valid = 1'b0;
    drain();
    chk("bp_second_word", got_at(1), {32'h47464544, 4'hF, 1'b0, 1'b0});
    flush_cycle();
    drain();

    // Flush of a three-pixel partial word, then a fresh frame
    got_q.delete();
    fd_count = 0;
    push_pix(8'hA0); push_pix(8'hA1); push_pix(8'hA2);
    flush_cycle();
    drain();
    chk("flush_word", got_at(0), {32'h00A2A1A0, 4'h7, 1'b1, 1'b1});
    chk("flush_frame_done", 38'(fd_count), 38'(1));
    push_pix(8'h55);
    flush_cycle();
    drain();
    chk("after_flush_tuser", got_at(1), {32'h00000055, 4'h1, 1'b1, 1'b1});

    // Asynchronous reset mid-row with a word queued
    got_q.delete();
    m_axis_tready = 1'b0;
    for (int p = 0; p < 5; p++) push_pix(8'hB0 + 8'(p));
    chk("pre_reset_tvalid", 38'(m_axis_tvalid), 38'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_tvalid", 38'(m_axis_tvalid), 38'(0));
    chk("async_reset_ready", 38'(s_pix_ready), 38'(0));
    exp_q.delete(); pend_q.delete(); pos = 0; pend_user = 0; armed = 0;
    tick(); tick();
    #3 rst_n = 1'b1;
    m_axis_tready = 1'b1;
    for (int p = 0; p < 4; p++) push_pix(8'hC0 + 8'(p));
    drain();
    chk("post_reset_word", got_at(0), {32'hC3C2C1C0, 4'hF, 1'b0, 1'b1});

    // Randomized traffic: three frames, random gaps, random tready, rare flushes
    flush_cycle();
    drain();
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < W * H; p++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        if ($urandom_range(0, 49) == 0) flush_cycle();
        push_pix(8'($urandom_range(0, 255)));
      end
    end
    drain();
    chk("final_pending_empty", 38'(exp_q.size()), 38'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
